// File: rtl/alu_share_arb_pkg.sv
// rtl/alu_share_arb_pkg.sv - shared widths and FSM encodings for the ALU sharing arbiter.
package alu_share_arb_pkg;
    localparam int WIDTH = 32;
    localparam int SELECT_WIDTH = 3;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_rr_pick.sv
// rtl/alu_rr_pick.sv - grant index pick; round-robin from ptr, or lowest-index-wins
// when ALU_SHARE_ARB_FIXED_PRIO_EN is defined.
module alu_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
    always_comb begin
        idx = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid[i]) begin
                idx = IDX_W'(i);
                found = 1'b1;
            end
        end
    end
`else
    logic [NUM_REQ-1:0] rot;

    // rot[i] is the requester i positions above the pointer, wrapping.
    assign rot = NUM_REQ'({valid, valid} >> ptr);

    always_comb begin
        idx = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin share of one registered ALU among NUM_REQ requesters,
// one op in flight; ALU_SHARE_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 1,
    parameter int IDX_W = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]      req_a,
    input  logic [NUM_REQ*WIDTH-1:0]      req_w,
    input  logic [NUM_REQ-1:0]            req_cin,
    input  logic [NUM_REQ*SELECT_WIDTH-1:0] req_s,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [WIDTH-1:0]              rsp_d,
    output logic                          rsp_cout,
    output logic [WIDTH-1:0]              alu_a,
    output logic [WIDTH-1:0]              alu_w,
    output logic                          alu_cin,
    output logic [SELECT_WIDTH-1:0]       alu_s,
    input  logic [WIDTH-1:0]              alu_d,
    input  logic                          alu_cout
);
    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] next_ptr;

    alu_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .valid(req_valid),
        .ptr  (ptr),
        .idx  (pick_idx),
        .found(pick_found)
    );

`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
    assign next_ptr = '0;
`else
    assign next_ptr = (gnt == IDX_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
`endif

    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && pick_found) req_ready[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            cnt       <= '0;
            alu_a     <= '0;
            alu_w     <= '0;
            alu_cin   <= 1'b0;
            alu_s     <= '0;
            rsp_d     <= '0;
            rsp_cout  <= 1'b0;
            rsp_valid <= '0;
        end else begin
            case (state)
                IDLE: if (pick_found) begin
                    alu_a   <= req_a[WIDTH*pick_idx +: WIDTH];
                    alu_w   <= req_w[WIDTH*pick_idx +: WIDTH];
                    alu_cin <= req_cin[pick_idx];
                    alu_s   <= req_s[SELECT_WIDTH*pick_idx +: SELECT_WIDTH];
                    gnt     <= pick_idx;
                    cnt     <= CNT_W'(ALU_LAT);
                    state   <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    // Count 1 means the ALU output settled on the held operands.
                    if (cnt == CNT_W'(1)) begin
                        rsp_d          <= alu_d;
                        rsp_cout       <= alu_cout;
                        rsp_valid[gnt] <= 1'b1;
                        state          <= RESP;
                    end
                end
                RESP: if (rsp_ready[gnt]) begin
                    rsp_valid <= '0;
                    ptr       <= next_ptr;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold_chk
        hold_valid: assert property (@(posedge clk) disable iff (rst)
            (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
    end
endmodule
